// File: rtl/kw_decision_pkg.sv
// kw_decision_pkg
//   Shared definitions for the keyword decision path: the background class
//   index, a constant-safe ceil(log2) helper and the frame-result record
//   handed from the argmax stage to the decision stage.
//   The record fields are sized to the widest supported id/score so the
//   struct is usable for any parameterisation; producers extend into it
//   and consumers take the low ID_W / SCORE_W bits.
package kw_decision_pkg;

   localparam int BG_CLASS       = 0;
   localparam int KW_ID_MAX_W    = 16;
   localparam int KW_SCORE_MAX_W = 32;

   // ceil(log2(value)); clog2(1) == 0
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   typedef struct packed {
      logic [KW_ID_MAX_W-1:0]    id;     // winning class index
      logic [KW_SCORE_MAX_W-1:0] score;  // winning score, sign-extended
      logic                      ok;     // one-cycle strobe: well-formed frame result
   } frame_result_t;

endpackage

// File: rtl/kw_argmax.sv
// kw_argmax
//   Streaming argmax over one frame of per-class scores.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     score_valid         beat present (always accepted)
//     score_data          signed class score; class index = beat order
//     score_last          final beat of the frame
//     result              registered frame result; result.ok pulses one
//                         cycle after an accepted, well-formed last beat
//     frame_error         one-cycle pulse one cycle after a framing error
module kw_argmax
   import kw_decision_pkg::*;
#(
   parameter int NUM_CLASSES = 10,
   parameter int SCORE_W     = 16,
   parameter int ID_W        = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      score_valid,
   input  logic signed [SCORE_W-1:0] score_data,
   input  logic                      score_last,
   output frame_result_t             result,
   output logic                      frame_error
);

   localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_CLASSES - 1);

   logic [ID_W-1:0]           idx_reg;
   logic [ID_W-1:0]           max_idx_reg;
   logic signed [SCORE_W-1:0] max_score_reg;

   logic                      is_last_idx;
   logic                      beat_error;
   logic                      take_new;
   logic [ID_W-1:0]           final_id;
   logic signed [SCORE_W-1:0] final_score;

   always_comb begin
      is_last_idx = (idx_reg == LAST_IDX);
      // Framing is broken when the last flag and the beat count disagree.
      beat_error  = score_valid && (score_last != is_last_idx);
      // Index 0 seeds the max; afterwards strict '>' keeps the lower index on ties.
      take_new    = (idx_reg == '0) || (score_data > max_score_reg);
      final_id    = take_new ? idx_reg    : max_idx_reg;
      final_score = take_new ? score_data : max_score_reg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_reg       <= '0;
         max_idx_reg   <= '0;
         max_score_reg <= '0;
         result        <= '0;
         frame_error   <= 1'b0;
      end else begin
         result.ok   <= 1'b0;
         frame_error <= 1'b0;
         if (score_valid) begin
            if (beat_error) begin
               idx_reg     <= '0;
               frame_error <= 1'b1;
            end else if (is_last_idx) begin
               // Snapshot the result so the next frame can start accumulating
               // in the very next cycle.
               idx_reg <= '0;
               result  <= '{id:    KW_ID_MAX_W'(final_id),
                            score: KW_SCORE_MAX_W'(final_score),
                            ok:    1'b1};
            end else begin
               idx_reg <= idx_reg + 1'b1;
               if (take_new) begin
                  max_idx_reg   <= idx_reg;
                  max_score_reg <= score_data;
               end
            end
         end
      end
   end

endmodule

// File: rtl/keyword_decision_unit.sv
// keyword_decision_unit
//   Post-classifier decision stage: frame argmax, confidence threshold,
//   multi-frame confirmation and refractory hold-off.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     score_valid/data/last  per-class score stream (no backpressure)
//     cfg_threshold       signed minimum winning score, sampled at decision
//     keyword_valid       one-cycle detection pulse
//     keyword_id          last detected class (held)
//     keyword_score       winning score of last detection (held)
//     frame_error         one-cycle pulse on a malformed frame
module keyword_decision_unit
   import kw_decision_pkg::*;
#(
   parameter int NUM_CLASSES = 10,
   parameter int SCORE_W     = 16,
   parameter int ID_W        = 4,
   parameter int CONFIRM     = 3,
   parameter int REFRACTORY  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      score_valid,
   input  logic signed [SCORE_W-1:0] score_data,
   input  logic                      score_last,
   input  logic signed [SCORE_W-1:0] cfg_threshold,
   output logic                      keyword_valid,
   output logic [ID_W-1:0]           keyword_id,
   output logic signed [SCORE_W-1:0] keyword_score,
   output logic                      frame_error
);

   localparam int STREAK_W = (clog2(CONFIRM + 1) < 1) ? 1 : clog2(CONFIRM + 1);
   localparam int REFR_W   = (clog2(REFRACTORY + 1) < 1) ? 1 : clog2(REFRACTORY + 1);
   localparam logic [STREAK_W-1:0] CONFIRM_V = STREAK_W'(CONFIRM);
   localparam logic [REFR_W-1:0]   REFR_V    = REFR_W'(REFRACTORY);

   frame_result_t frame_res;

   kw_argmax #(
      .NUM_CLASSES (NUM_CLASSES),
      .SCORE_W     (SCORE_W),
      .ID_W        (ID_W)
   ) u_argmax (
      .clk         (clk),
      .rst         (rst),
      .score_valid (score_valid),
      .score_data  (score_data),
      .score_last  (score_last),
      .result      (frame_res),
      .frame_error (frame_error)
   );

   logic [STREAK_W-1:0]       streak_reg, streak_next;
   logic [ID_W-1:0]           cand_reg, cand_next;
   logic [REFR_W-1:0]         refr_reg, refr_next;
   logic                      fire;
   logic                      passes;
   logic [ID_W-1:0]           winner_id;
   logic signed [SCORE_W-1:0] winner_score;

   // The record carries widened fields; only the low bits matter here.
   logic unused_result_bits;
   assign unused_result_bits = ^frame_res;

   always_comb begin
      winner_id    = frame_res.id[ID_W-1:0];
      winner_score = $signed(frame_res.score[SCORE_W-1:0]);
      passes       = (winner_id != ID_W'(BG_CLASS)) && (winner_score >= cfg_threshold);

      streak_next = streak_reg;
      cand_next   = cand_reg;
      refr_next   = refr_reg;
      fire        = 1'b0;

      if (frame_error) begin
         // Discarded frame breaks confirmation but does not age refractory.
         streak_next = '0;
         cand_next   = '0;
      end else if (frame_res.ok) begin
         if (!passes) begin
            streak_next = '0;
            cand_next   = '0;
         end else if (winner_id == cand_reg) begin
            streak_next = (streak_reg == CONFIRM_V) ? CONFIRM_V : streak_reg + 1'b1;
         end else begin
            cand_next   = winner_id;
            streak_next = STREAK_W'(1);
         end

         // Fire only on the frame where the streak first reaches CONFIRM;
         // a saturated streak (same candidate) never re-fires, so a
         // confirmation swallowed by refractory is not fired later.
         fire = passes && (streak_next == CONFIRM_V) &&
                ((streak_reg != CONFIRM_V) || (winner_id != cand_reg)) &&
                (refr_reg == '0);

         if (fire) begin
            refr_next = REFR_V;
         end else if (refr_reg != '0) begin
            refr_next = refr_reg - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         streak_reg    <= '0;
         cand_reg      <= '0;
         refr_reg      <= '0;
         keyword_valid <= 1'b0;
         keyword_id    <= '0;
         keyword_score <= '0;
      end else begin
         streak_reg    <= streak_next;
         cand_reg      <= cand_next;
         refr_reg      <= refr_next;
         keyword_valid <= fire;
         if (fire) begin
            keyword_id    <= winner_id;
            keyword_score <= winner_score;
         end
      end
   end

endmodule
